jogador_automatico: RTL and testbench

//  Synthesizable automatic player for jogo_desafio_memoria: watches the game's leds output,

---
 rtl/jogador_automatico.sv | 197 +++++++++++++++++++
 tb/tb_jogador_automatico.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jogador_automatico.sv
// Automatic player for jogo_desafio_memoria: records the one-hot LEDs shown in a round and
// replays them on botoes. Optional JOGADOR_ERRO_EN adds an errar input that corrupts the last press.
module jogador_automatico #(
    parameter int MAX_JOGADAS  = 16,
    parameter int T_PRESSIONA  = 500,
    parameter int T_SOLTA      = 300,
    parameter int T_FIM_MOSTRA = 1500
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       habilitar,
    input  logic [3:0] leds,
    input  logic       pronto,
    input  logic       ganhou,
    input  logic       perdeu,
`ifdef JOGADOR_ERRO_EN
    input  logic       errar,
`endif
    output logic [3:0] botoes,
    output logic       jogando,
    output logic       overflow,
    output logic [4:0] db_contagem,
    output logic [2:0] db_estado
);

    localparam int T_MAX_A = (T_PRESSIONA > T_SOLTA) ? T_PRESSIONA : T_SOLTA;
    localparam int T_MAX   = (T_MAX_A > T_FIM_MOSTRA) ? T_MAX_A : T_FIM_MOSTRA;
    localparam int TW      = (T_MAX > 1) ? $clog2(T_MAX) : 1;
    localparam int AW      = (MAX_JOGADAS > 1) ? $clog2(MAX_JOGADAS) : 1;
    localparam int CW      = AW + 1;

    localparam logic [TW-1:0] PRESS_LAST = TW'(T_PRESSIONA - 1);
    localparam logic [TW-1:0] SOLTA_LAST = TW'(T_SOLTA - 1);
    localparam logic [TW-1:0] FIM_LAST   = TW'(T_FIM_MOSTRA - 1);
    localparam logic [CW-1:0] COUNT_MAX  = CW'(MAX_JOGADAS);

    typedef enum logic [2:0] {
        OCIOSO         = 3'd0,
        ESPERA_LED     = 3'd1,
        ESPERA_APAGA   = 3'd2,
        JOGA_PRESSIONA = 3'd3,
        JOGA_SOLTA     = 3'd4,
        FIM            = 3'd5
    } estado_t;

    estado_t       state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] ptr_q, ptr_d;
    logic [3:0]    botoes_q, botoes_d;
    logic          overflow_q, overflow_d;
    logic          jogando_q;
    logic          mem_we;
    logic [3:0]    mem_q [MAX_JOGADAS];

    logic          led_one_hot;
    logic          fim_jogo;
    logic [CW-1:0] ptr_inc;
    logic [CW-1:0] press_idx;
    logic [3:0]    press_v;

    assign led_one_hot = (leds != 4'b0) && ((leds & (leds - 4'd1)) == 4'b0);
    assign fim_jogo    = pronto | ganhou | perdeu;
    assign ptr_inc     = ptr_q + CW'(1);

    // Value driven when a press starts: entry 0 from the show phase, else the next entry.
    always_comb begin
        press_idx = (state_q == JOGA_SOLTA) ? ptr_inc : '0;
        press_v   = mem_q[press_idx[AW-1:0]];
`ifdef JOGADOR_ERRO_EN
        if (errar && (press_idx == count_q - CW'(1))) begin
            press_v = {press_v[2:0], press_v[3]};
        end
`endif
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        count_d    = count_q;
        ptr_d      = ptr_q;
        botoes_d   = 4'b0;
        overflow_d = overflow_q;
        mem_we     = 1'b0;
        if (!habilitar) begin
            state_d    = OCIOSO;
            timer_d    = '0;
            count_d    = '0;
            ptr_d      = '0;
            overflow_d = 1'b0;
        end else if (state_q != OCIOSO && fim_jogo) begin
            state_d = FIM;
        end else begin
            case (state_q)
                OCIOSO: begin
                    state_d = ESPERA_LED;
                    timer_d = '0;
                    count_d = '0;
                    ptr_d   = '0;
                end
                ESPERA_LED: begin
                    if (led_one_hot) begin
                        if (count_q == COUNT_MAX) begin
                            overflow_d = 1'b1;
                        end else begin
                            mem_we  = 1'b1;
                            count_d = count_q + CW'(1);
                        end
                        state_d = ESPERA_APAGA;
                        timer_d = '0;
                    end else if (leds == 4'b0) begin
                        // With nothing recorded the timer parks at its last value.
                        if (timer_q == FIM_LAST) begin
                            if (count_q != '0) begin
                                state_d  = JOGA_PRESSIONA;
                                ptr_d    = '0;
                                timer_d  = '0;
                                botoes_d = press_v;
                            end
                        end else begin
                            timer_d = timer_q + TW'(1);
                        end
                    end else begin
                        timer_d = '0;
                    end
                end
                ESPERA_APAGA: begin
                    if (leds == 4'b0) begin
                        state_d = ESPERA_LED;
                        timer_d = '0;
                    end
                end
                JOGA_PRESSIONA: begin
                    botoes_d = botoes_q;
                    if (timer_q == PRESS_LAST) begin
                        state_d  = JOGA_SOLTA;
                        timer_d  = '0;
                        botoes_d = 4'b0;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                JOGA_SOLTA: begin
                    if (timer_q == SOLTA_LAST) begin
                        timer_d = '0;
                        if (ptr_inc == count_q) begin
                            state_d = ESPERA_LED;
                            count_d = '0;
                            ptr_d   = '0;
                        end else begin
                            state_d  = JOGA_PRESSIONA;
                            ptr_d    = ptr_inc;
                            botoes_d = press_v;
                        end
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                FIM: state_d = FIM;
                default: state_d = OCIOSO;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= OCIOSO;
            timer_q    <= '0;
            count_q    <= '0;
            ptr_q      <= '0;
            botoes_q   <= 4'b0;
            overflow_q <= 1'b0;
            jogando_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            count_q    <= count_d;
            ptr_q      <= ptr_d;
            botoes_q   <= botoes_d;
            overflow_q <= overflow_d;
            jogando_q  <= (state_d == JOGA_PRESSIONA) || (state_d == JOGA_SOLTA);
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem_q[count_q[AW-1:0]] <= leds;
        end
    end

    assign botoes      = botoes_q;
    assign jogando     = jogando_q;
    assign overflow    = overflow_q;
    assign db_contagem = 5'(count_q);
    assign db_estado   = state_q;

endmodule

// File: tb/tb_jogador_automatico.sv
// Directed bench for jogador_automatico with short timing (press 5, release 3, idle end 15).
module tb_jogador_automatico;

    logic       clock;
    logic       reset;
    logic       habilitar;
    logic [3:0] leds;
    logic       pronto;
    logic       ganhou;
    logic       perdeu;
`ifdef JOGADOR_ERRO_EN
    logic       errar;
`endif
    logic [3:0] botoes;
    logic       jogando;
    logic       overflow;
    logic [4:0] db_contagem;
    logic [2:0] db_estado;

    int n_checks = 0;
    int n_fail   = 0;
    logic [3:0] exp_q [$];

    jogador_automatico #(
        .MAX_JOGADAS (16),
        .T_PRESSIONA (5),
        .T_SOLTA     (3),
        .T_FIM_MOSTRA(15)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .habilitar  (habilitar),
        .leds       (leds),
        .pronto     (pronto),
        .ganhou     (ganhou),
        .perdeu     (perdeu),
`ifdef JOGADOR_ERRO_EN
        .errar      (errar),
`endif
        .botoes     (botoes),
        .jogando    (jogando),
        .overflow   (overflow),
        .db_contagem(db_contagem),
        .db_estado  (db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        habilitar = 1'b0;
        pronto    = 1'b0;
        ganhou    = 1'b0;
        perdeu    = 1'b0;
`ifdef JOGADOR_ERRO_EN
        errar     = 1'b0;
`endif
        for (int i = 0; i < 2; i++) begin
            leds = (i % 2 == 0) ? 4'b1111 : 4'b0101;
            tick();
        end
        leds  = 4'b0;
        reset = 1'b1;
    endtask

    task automatic show_led(input logic [3:0] v, input int on_c, input int off_c);
        leds = v;
        for (int i = 0; i < on_c; i++) tick();
        leds = 4'b0;
        for (int i = 0; i < off_c; i++) tick();
    endtask

    task automatic wait_press(output bit ok);
        int n;
        n = 0;
        while (botoes == 4'b0 && n < 200) begin
            tick();
            n++;
        end
        ok = (botoes != 4'b0);
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL press_timeout: no press within 200 cycles, botoes=0x%0h", botoes);
        end
    endtask

    // Pops exp_q in order and checks each press (5 cycles) and release (3 cycles).
    task automatic replay_check(input bit echo);
        bit ok;
        logic [3:0] v;
        wait_press(ok);
        if (!ok) begin
            exp_q.delete();
            return;
        end
        while (exp_q.size() > 0) begin
            v = exp_q.pop_front();
            for (int i = 0; i < 5; i++) begin
                chk("press_value", botoes, v);
                chk("press_jogando", jogando, 1);
                leds = echo ? botoes : 4'b0;
                tick();
            end
            for (int i = 0; i < 3; i++) begin
                chk("release_value", botoes, 0);
                chk("release_jogando", jogando, 1);
                leds = echo ? botoes : 4'b0;
                tick();
            end
        end
        leds = 4'b0;
        chk("replay_end_estado", db_estado, 1);
        chk("replay_end_contagem", db_contagem, 0);
        chk("replay_end_jogando", jogando, 0);
    endtask

    typedef struct {
        logic       hab;
        logic [3:0] leds;
        logic       p;
        logic       g;
        logic       l;
        logic [2:0] exp_estado;
        logic [4:0] exp_cont;
    } vec_t;

    vec_t tbl [18];

    initial begin
        bit ok;
        logic [3:0] v;

        tbl[0]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0};
        tbl[1]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 3'd1, 5'd0};
        tbl[2]  = '{1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 3'd1, 5'd0};
        tbl[3]  = '{1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 3'd2, 5'd1};
        tbl[4]  = '{1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 3'd2, 5'd1};
        tbl[5]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 3'd1, 5'd1};
        tbl[6]  = '{1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 3'd5, 5'd1};
        tbl[7]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 3'd5, 5'd1};
        tbl[8]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0};
        tbl[9]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 3'd1, 5'd0};
        tbl[10] = '{1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 3'd5, 5'd0};
        tbl[11] = '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 3'd0, 5'd0};
        tbl[12] = '{1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 3'd1, 5'd0};
        tbl[13] = '{1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 3'd5, 5'd0};
        tbl[14] = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0};
        tbl[15] = '{1'b1, 4'b1000, 1'b0, 1'b0, 1'b0, 3'd1, 5'd0};
        tbl[16] = '{1'b1, 4'b1000, 1'b0, 1'b0, 1'b0, 3'd2, 5'd1};
        tbl[17] = '{1'b1, 4'b0101, 1'b0, 1'b0, 1'b0, 3'd2, 5'd1};

        // Reset with leds toggling
        do_reset();
        chk("reset_botoes", botoes, 0);
        chk("reset_estado", db_estado, 0);
        chk("reset_contagem", db_contagem, 0);
        chk("reset_jogando", jogando, 0);
        chk("reset_overflow", overflow, 0);

        // Single-cycle control vectors
        for (int i = 0; i < 18; i++) begin
            habilitar = tbl[i].hab;
            leds      = tbl[i].leds;
            pronto    = tbl[i].p;
            ganhou    = tbl[i].g;
            perdeu    = tbl[i].l;
            tick();
            chk($sformatf("vec%0d_estado", i), db_estado, tbl[i].exp_estado);
            chk($sformatf("vec%0d_contagem", i), db_contagem, tbl[i].exp_cont);
            chk($sformatf("vec%0d_botoes", i), botoes, 0);
        end
        pronto = 1'b0;
        ganhou = 1'b0;
        perdeu = 1'b0;

        // Single LED round
        do_reset();
        habilitar = 1'b1;
        tick();
        leds = 4'b0100;
        for (int i = 0; i < 10; i++) tick();
        chk("single_contagem", db_contagem, 1);
        chk("single_estado_apaga", db_estado, 2);
        leds = 4'b0;
        exp_q.push_back(4'b0100);
        replay_check(1'b0);

        // Three LEDs, replay with game echo on leds
        show_led(4'b0001, 4, 8);
        show_led(4'b1000, 4, 8);
        show_led(4'b0010, 4, 8);
        chk("three_contagem", db_contagem, 3);
        chk("three_estado", db_estado, 1);
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b1000);
        exp_q.push_back(4'b0010);
        replay_check(1'b1);

        // Game won during a press
        show_led(4'b0010, 4, 0);
        wait_press(ok);
        if (ok) begin
            ganhou = 1'b1;
            tick();
            chk("ganhou_estado", db_estado, 5);
            chk("ganhou_botoes", botoes, 0);
            chk("ganhou_jogando", jogando, 0);
            ganhou = 1'b0;
            tick();
            chk("fim_held_estado", db_estado, 5);
            chk("fim_held_contagem", db_contagem, 1);
        end
        habilitar = 1'b0;
        tick();
        chk("fim_exit_estado", db_estado, 0);
        chk("fim_exit_contagem", db_contagem, 0);

        // Overflow: 17 LEDs, 16 stored and replayed
        habilitar = 1'b1;
        tick();
        for (int i = 0; i < 17; i++) begin
            v = 4'b0001 << $urandom_range(0, 3);
            show_led(v, 2, 3);
            if (i < 16) exp_q.push_back(v);
            if (i == 15) chk("overflow_before", overflow, 0);
        end
        chk("overflow_set", overflow, 1);
        chk("overflow_contagem", db_contagem, 16);
        replay_check(1'b0);
        chk("overflow_sticky", overflow, 1);
        habilitar = 1'b0;
        tick();
        chk("overflow_cleared", overflow, 0);

        // habilitar dropped mid-press
        habilitar = 1'b1;
        tick();
        show_led(4'b1000, 4, 0);
        wait_press(ok);
        if (ok) begin
            chk("drop_press_value", botoes, 4'b1000);
            habilitar = 1'b0;
            tick();
            chk("drop_botoes", botoes, 0);
            chk("drop_estado", db_estado, 0);
            chk("drop_contagem", db_contagem, 0);
            chk("drop_jogando", jogando, 0);
        end

`ifdef JOGADOR_ERRO_EN
        // Forced error on the last entry of the round
        habilitar = 1'b1;
        errar     = 1'b1;
        tick();
        show_led(4'b0001, 4, 4);
        show_led(4'b1000, 4, 0);
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0001);
        replay_check(1'b0);
        errar = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
